// File: rtl/secuenciador_nand_if.sv
// -----------------------------------------------------------------------------
// secuenciador_nand_if
// Start/done handshake and operand/result bus between a requester and the
// NAND sequencer.
//   Inicio     : start request (requester -> sequencer)
//   Operacion  : 00 AND, 01 OR, 10 XOR, 11 NOT (of OperandoA)
//   OperandoA/B: operands, ANCHO bits each
//   Ocupado    : request in flight
//   Listo      : one-cycle pulse, Salida holds a new result
//   Salida     : registered result, ANCHO bits
// -----------------------------------------------------------------------------
interface secuenciador_nand_if #(
  parameter int unsigned ANCHO = 4
);
  logic             Inicio;
  logic [1:0]       Operacion;
  logic [ANCHO-1:0] OperandoA;
  logic [ANCHO-1:0] OperandoB;
  logic             Ocupado;
  logic             Listo;
  logic [ANCHO-1:0] Salida;

  modport master (
    output Inicio, Operacion, OperandoA, OperandoB,
    input  Ocupado, Listo, Salida
  );

  modport slave (
    input  Inicio, Operacion, OperandoA, OperandoB,
    output Ocupado, Listo, Salida
  );
endinterface

// File: rtl/secuenciador_nand.sv
// -----------------------------------------------------------------------------
// secuenciador_nand
// Evaluates AND / OR / XOR / NOT of two ANCHO-bit operands by routing them
// through a single shared ANCHO-bit NAND stage, one NAND per clock.
// Ports:
//   i_reloj    : clock, rising edge
//   i_reset_n  : synchronous active-low reset
//   bus        : slave side of secuenciador_nand_if (Inicio/Operacion/
//                OperandoA/OperandoB in, Ocupado/Listo/Salida out)
// Latency for S steps (AND 2, OR 3, XOR 4, NOT 1): Salida and Listo at
// E0+S, Ocupado low at E0+S+1, next acceptance at E0+S+2.
// -----------------------------------------------------------------------------
module secuenciador_nand #(
  parameter int unsigned ANCHO = 4
) (
  input  logic                 i_reloj,
  input  logic                 i_reset_n,
  secuenciador_nand_if.slave   bus
);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    PASO   = 2'd1,
    FIN    = 2'd2
  } estado_t;

  // Mux select codes over {RA, RB, T1, T2}
  localparam logic [1:0] SEL_RA = 2'd0;
  localparam logic [1:0] SEL_RB = 2'd1;
  localparam logic [1:0] SEL_T1 = 2'd2;
  localparam logic [1:0] SEL_T2 = 2'd3;

  // Destination codes for the NAND result
  localparam logic [1:0] DST_T1  = 2'd0;
  localparam logic [1:0] DST_T2  = 2'd1;
  localparam logic [1:0] DST_SAL = 2'd2;
  localparam logic [1:0] DST_NIN = 2'd3;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  estado_t          r_estado;
  logic [ANCHO-1:0] r_ra;
  logic [ANCHO-1:0] r_rb;
  logic [1:0]       r_op;
  logic [ANCHO-1:0] r_t1;
  logic [ANCHO-1:0] r_t2;
  logic [1:0]       r_paso;
  logic [ANCHO-1:0] r_salida;
  logic             r_ocupado;
  logic             r_listo;

  logic [1:0]       w_sel_x;
  logic [1:0]       w_sel_y;
  logic [1:0]       w_dest;
  logic             w_ultimo;
  logic [ANCHO-1:0] w_x;
  logic [ANCHO-1:0] w_y;
  wire  [ANCHO-1:0] w_n;

  // Step table: operand selects, destination and last-step flag per (op, paso)
  always_comb begin
    w_sel_x  = SEL_RA;
    w_sel_y  = SEL_RA;
    w_dest   = DST_NIN;
    w_ultimo = 1'b1;
    unique case (r_op)
      OP_AND: begin
        unique case (r_paso)
          2'd0: begin w_sel_x = SEL_RA; w_sel_y = SEL_RB; w_dest = DST_T1;  w_ultimo = 1'b0; end
          2'd1: begin w_sel_x = SEL_T1; w_sel_y = SEL_T1; w_dest = DST_SAL; w_ultimo = 1'b1; end
          default: ;
        endcase
      end
      OP_OR: begin
        unique case (r_paso)
          2'd0: begin w_sel_x = SEL_RA; w_sel_y = SEL_RA; w_dest = DST_T1;  w_ultimo = 1'b0; end
          2'd1: begin w_sel_x = SEL_RB; w_sel_y = SEL_RB; w_dest = DST_T2;  w_ultimo = 1'b0; end
          2'd2: begin w_sel_x = SEL_T1; w_sel_y = SEL_T2; w_dest = DST_SAL; w_ultimo = 1'b1; end
          default: ;
        endcase
      end
      OP_XOR: begin
        unique case (r_paso)
          2'd0: begin w_sel_x = SEL_RA; w_sel_y = SEL_RB; w_dest = DST_T1;  w_ultimo = 1'b0; end
          2'd1: begin w_sel_x = SEL_RA; w_sel_y = SEL_T1; w_dest = DST_T2;  w_ultimo = 1'b0; end
          // T1 is read and rewritten here; the write lands at the edge
          2'd2: begin w_sel_x = SEL_RB; w_sel_y = SEL_T1; w_dest = DST_T1;  w_ultimo = 1'b0; end
          2'd3: begin w_sel_x = SEL_T2; w_sel_y = SEL_T1; w_dest = DST_SAL; w_ultimo = 1'b1; end
          default: ;
        endcase
      end
      OP_NOT: begin
        w_sel_x  = SEL_RA;
        w_sel_y  = SEL_RA;
        w_dest   = DST_SAL;
        w_ultimo = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand muxes feeding the shared NAND stage
  always_comb begin
    w_x = r_ra;
    w_y = r_ra;
    unique case (w_sel_x)
      SEL_RA: w_x = r_ra;
      SEL_RB: w_x = r_rb;
      SEL_T1: w_x = r_t1;
      SEL_T2: w_x = r_t2;
      default: w_x = r_ra;
    endcase
    unique case (w_sel_y)
      SEL_RA: w_y = r_ra;
      SEL_RB: w_y = r_rb;
      SEL_T1: w_y = r_t1;
      SEL_T2: w_y = r_t2;
      default: w_y = r_ra;
    endcase
  end

  // The only logic gate of the datapath: one nand per bit
  for (genvar i = 0; i < int'(ANCHO); i++) begin : g_nand
    nand u_nand (w_n[i], w_x[i], w_y[i]);
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge i_reloj) begin
    if (!i_reset_n) begin
      r_estado  <= REPOSO;
      r_ra      <= '0;
      r_rb      <= '0;
      r_op      <= OP_AND;
      r_t1      <= '0;
      r_t2      <= '0;
      r_paso    <= 2'd0;
      r_salida  <= '0;
      r_ocupado <= 1'b0;
      r_listo   <= 1'b0;
    end else begin
      unique case (r_estado)
        REPOSO: begin
          r_listo <= 1'b0;
          if (bus.Inicio) begin
            r_ra      <= bus.OperandoA;
            r_rb      <= bus.OperandoB;
            r_op      <= bus.Operacion;
            r_paso    <= 2'd0;
            r_ocupado <= 1'b1;
            r_estado  <= PASO;
          end
        end
        PASO: begin
          unique case (w_dest)
            DST_T1:  r_t1     <= w_n;
            DST_T2:  r_t2     <= w_n;
            DST_SAL: r_salida <= w_n;
            default: ;
          endcase
          if (w_ultimo) begin
            r_listo  <= 1'b1;
            r_estado <= FIN;
          end else begin
            r_paso <= r_paso + 2'd1;
          end
        end
        FIN: begin
          r_listo   <= 1'b0;
          r_ocupado <= 1'b0;
          r_estado  <= REPOSO;
        end
        default: begin
          r_listo   <= 1'b0;
          r_ocupado <= 1'b0;
          r_estado  <= REPOSO;
        end
      endcase
    end
  end

  assign bus.Ocupado = r_ocupado;
  assign bus.Listo   = r_listo;
  assign bus.Salida  = r_salida;

endmodule
